// File: rtl/frogger_pkg.sv
// Shared types and constants for the frog sprite animator and its hop controller.
package frogger_pkg;

  localparam int FROG_COLOR_W = 6;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOP  = 1'b1
  } hop_state_t;

  typedef logic [FROG_COLOR_W-1:0] color_t;

  localparam color_t COLOR_BLACK       = '0;
  localparam color_t COLOR_KEY_DEFAULT = '0;

  // Up and left move toward the origin.
  function automatic logic dir_is_negative(input dir_t d);
    return (d == DIR_UP) || (d == DIR_LEFT);
  endfunction

endpackage

// File: rtl/frog_hop_ctrl.sv
// Hop state machine: committed position, facing, in-flight draw position and frame index.
// Draw position and frame only move on frame_tick so a frame is never torn.
module frog_hop_ctrl
  import frogger_pkg::*;
#(
  parameter int FRAMES    = 4,
  parameter int HOP_PX    = 32,
  parameter int HOP_TICKS = 8,
  parameter int X_MAX     = 608,
  parameter int Y_MAX     = 448,
  parameter int FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          spawn,
  input  logic [9:0]    spawn_x,
  input  logic [9:0]    spawn_y,
  input  logic          hop_req,
  input  logic [1:0]    hop_dir,
  output logic          hop_ready,
  output logic          hop_done,
  output logic [9:0]    frog_x,
  output logic [9:0]    frog_y,
  output logic [9:0]    draw_x,
  output logic [9:0]    draw_y,
  output dir_t          facing,
  output logic [FW-1:0] frame
);

  localparam int HTW = (HOP_TICKS > 1) ? $clog2(HOP_TICKS) : 1;
  localparam int TW  = HTW + 1;
  localparam logic [TW-1:0] LAST_STEP = TW'(HOP_TICKS - 1);
  localparam logic [11:0]   HOP_PX12  = 12'(HOP_PX);
  localparam logic [11:0]   X_MAX12   = 12'(X_MAX);
  localparam logic [11:0]   Y_MAX12   = 12'(Y_MAX);

  hop_state_t    state_reg, state_next;
  dir_t          dir_reg, facing_reg;
  logic [FW-1:0] frame_reg;
  logic [TW-1:0] step_reg;
  logic [9:0]    pos_x_reg, pos_y_reg;
  logic [9:0]    target_x_reg, target_y_reg;
  logic [9:0]    draw_x_reg, draw_y_reg;
  logic          hop_done_reg;

  dir_t          req_dir;
  logic          hop_acc;
  logic          in_bounds;
  logic          last_step;
  logic [11:0]   cand_x, cand_y;
  logic [TW-1:0] step_inc;
  logic [11:0]   hop_ofs;
  logic [FW-1:0] frame_inc;
  logic [11:0]   step_x, step_y;

  assign req_dir   = dir_t'(hop_dir);
  assign hop_acc   = hop_req && (state_reg == IDLE);
  assign last_step = (step_reg == LAST_STEP);
  assign step_inc  = step_reg + 1'b1;

  // Tick counts are powers of two, so the scaling divide is a shift.
  assign hop_ofs   = 12'((32'(step_inc) * 32'(HOP_PX)) >> HTW);
  assign frame_inc = FW'((32'(step_inc) * 32'(FRAMES)) >> HTW);

  // Candidate landing spot and bounds check for a requested hop.
  always_comb begin
    cand_x    = {2'b00, pos_x_reg};
    cand_y    = {2'b00, pos_y_reg};
    in_bounds = 1'b1;
    unique case (req_dir)
      DIR_UP: begin
        if ({2'b00, pos_y_reg} < HOP_PX12) in_bounds = 1'b0;
        else cand_y = {2'b00, pos_y_reg} - HOP_PX12;
      end
      DIR_DOWN: begin
        cand_y = {2'b00, pos_y_reg} + HOP_PX12;
        if (cand_y > Y_MAX12) in_bounds = 1'b0;
      end
      DIR_LEFT: begin
        if ({2'b00, pos_x_reg} < HOP_PX12) in_bounds = 1'b0;
        else cand_x = {2'b00, pos_x_reg} - HOP_PX12;
      end
      DIR_RIGHT: begin
        cand_x = {2'b00, pos_x_reg} + HOP_PX12;
        if (cand_x > X_MAX12) in_bounds = 1'b0;
      end
      default: in_bounds = 1'b0;
    endcase
  end

  // Intermediate draw position for the next step of the current hop.
  always_comb begin
    step_x = {2'b00, pos_x_reg};
    step_y = {2'b00, pos_y_reg};
    if (dir_reg == DIR_UP || dir_reg == DIR_DOWN) begin
      if (dir_is_negative(dir_reg)) step_y = {2'b00, pos_y_reg} - hop_ofs;
      else                          step_y = {2'b00, pos_y_reg} + hop_ofs;
    end else begin
      if (dir_is_negative(dir_reg)) step_x = {2'b00, pos_x_reg} - hop_ofs;
      else                          step_x = {2'b00, pos_x_reg} + hop_ofs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (spawn) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (hop_acc && in_bounds) state_next = HOP;
        HOP:     if (frame_tick && last_step) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    hop_ready = (state_reg == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_reg      <= DIR_UP;
      facing_reg   <= DIR_UP;
      frame_reg    <= '0;
      step_reg     <= '0;
      pos_x_reg    <= '0;
      pos_y_reg    <= '0;
      target_x_reg <= '0;
      target_y_reg <= '0;
      draw_x_reg   <= '0;
      draw_y_reg   <= '0;
      hop_done_reg <= 1'b0;
    end else if (spawn) begin
      facing_reg   <= DIR_UP;
      frame_reg    <= '0;
      step_reg     <= '0;
      pos_x_reg    <= spawn_x;
      pos_y_reg    <= spawn_y;
      draw_x_reg   <= spawn_x;
      draw_y_reg   <= spawn_y;
      hop_done_reg <= 1'b0;
    end else begin
      hop_done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        // A blocked hop still turns the frog to face the wall.
        if (hop_acc) begin
          facing_reg <= req_dir;
          if (in_bounds) begin
            dir_reg      <= req_dir;
            target_x_reg <= cand_x[9:0];
            target_y_reg <= cand_y[9:0];
            step_reg     <= '0;
            frame_reg    <= '0;
          end
        end
      end else if (frame_tick) begin
        step_reg <= step_inc;
        if (last_step) begin
          pos_x_reg    <= target_x_reg;
          pos_y_reg    <= target_y_reg;
          draw_x_reg   <= target_x_reg;
          draw_y_reg   <= target_y_reg;
          frame_reg    <= '0;
          hop_done_reg <= 1'b1;
        end else begin
          draw_x_reg <= step_x[9:0];
          draw_y_reg <= step_y[9:0];
          frame_reg  <= frame_inc;
        end
      end
    end
  end

  assign hop_done = hop_done_reg;
  assign frog_x   = pos_x_reg;
  assign frog_y   = pos_y_reg;
  assign draw_x   = draw_x_reg;
  assign draw_y   = draw_y_reg;
  assign facing   = facing_reg;
  assign frame    = frame_reg;

endmodule

// File: rtl/frog_sprite_anim.sv
// Frog sprite animator: hop controller plus a 3-stage pixel pipeline through a synchronous sprite ROM.
// Optional TRANSPARENT_KEY_EN makes pixels equal to KEY_COLOR see-through.
module frog_sprite_anim
  import frogger_pkg::*;
#(
  parameter int SPRITE_W  = 32,
  parameter int FRAMES    = 4,
  parameter int HOP_PX    = 32,
  parameter int HOP_TICKS = 8,
  parameter int X_MAX     = 608,
  parameter int Y_MAX     = 448,
  parameter int COLOR_W   = FROG_COLOR_W,
  parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(COLOR_KEY_DEFAULT),
  parameter int SW        = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  parameter int FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  parameter int AW        = 2 + FW + 2 * SW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               spawn,
  input  logic [9:0]         spawn_x,
  input  logic [9:0]         spawn_y,
  input  logic               hop_req,
  input  logic [1:0]         hop_dir,
  output logic               hop_ready,
  output logic               hop_done,
  output logic [9:0]         frog_x,
  output logic [9:0]         frog_y,
  input  logic [9:0]         colPos,
  input  logic [9:0]         rowPos,
  output logic [AW-1:0]      rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] color,
  output logic               opaque
);

  logic [9:0]    draw_x, draw_y;
  dir_t          facing;
  logic [FW-1:0] frame;

  frog_hop_ctrl #(
    .FRAMES    (FRAMES),
    .HOP_PX    (HOP_PX),
    .HOP_TICKS (HOP_TICKS),
    .X_MAX     (X_MAX),
    .Y_MAX     (Y_MAX),
    .FW        (FW)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .spawn      (spawn),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .hop_req    (hop_req),
    .hop_dir    (hop_dir),
    .hop_ready  (hop_ready),
    .hop_done   (hop_done),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .facing     (facing),
    .frame      (frame)
  );

  logic [10:0]        col_ext, row_ext;
  logic [10:0]        x_lo, x_hi, y_lo, y_hi;
  logic               in_sprite_c0;
  logic [SW-1:0]      local_x, local_y;
  logic [AW-1:0]      rom_addr_reg;
  logic               in_sprite_c1_reg, in_sprite_c2_reg;
  logic [COLOR_W-1:0] color_reg;
  logic               opaque_reg;
  logic               key_hit;
  logic               pixel_opaque;
  logic [COLOR_W-1:0] pixel_color;

  // 11-bit compare so the right/bottom edge never wraps past 1023.
  assign col_ext = {1'b0, colPos};
  assign row_ext = {1'b0, rowPos};
  assign x_lo    = {1'b0, draw_x};
  assign y_lo    = {1'b0, draw_y};
  assign x_hi    = x_lo + 11'(SPRITE_W);
  assign y_hi    = y_lo + 11'(SPRITE_W);

  assign in_sprite_c0 = (col_ext >= x_lo) && (col_ext < x_hi) &&
                        (row_ext >= y_lo) && (row_ext < y_hi);
  assign local_x = SW'(colPos - draw_x);
  assign local_y = SW'(rowPos - draw_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_reg     <= '0;
      in_sprite_c1_reg <= 1'b0;
      in_sprite_c2_reg <= 1'b0;
    end else begin
      rom_addr_reg     <= {facing, frame, local_y, local_x};
      in_sprite_c1_reg <= in_sprite_c0;
      in_sprite_c2_reg <= in_sprite_c1_reg;
    end
  end

  assign key_hit = (rom_data == KEY_COLOR);

  always_comb begin
    pixel_opaque = in_sprite_c2_reg;
    pixel_color  = rom_data;
`ifdef TRANSPARENT_KEY_EN
    if (key_hit) pixel_opaque = 1'b0;
`else
    // Key pixels pass through as their own colour.
    if (key_hit) pixel_color = KEY_COLOR;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_reg  <= '0;
      opaque_reg <= 1'b0;
    end else begin
      color_reg  <= pixel_opaque ? pixel_color : '0;
      opaque_reg <= pixel_opaque;
    end
  end

  assign rom_addr = rom_addr_reg;
  assign color    = color_reg;
  assign opaque   = opaque_reg;

endmodule

// File: tb/tb_frog_sprite_anim.sv
// Directed self-checking bench for frog_sprite_anim with a small synchronous ROM model.
module tb_frog_sprite_anim;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, spawn, hop_req;
  logic [9:0]  spawn_x, spawn_y;
  logic [1:0]  hop_dir;
  logic        hop_ready, hop_done;
  logic [9:0]  frog_x, frog_y;
  logic [9:0]  colPos, rowPos;
  logic [13:0] rom_addr;
  logic [5:0]  rom_data;
  logic [5:0]  color;
  logic        opaque;
  logic        rom_zero;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  always #5 clk = ~clk;

  frog_sprite_anim u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .spawn      (spawn),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .hop_req    (hop_req),
    .hop_dir    (hop_dir),
    .hop_ready  (hop_ready),
    .hop_done   (hop_done),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .colPos     (colPos),
    .rowPos     (rowPos),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .color      (color),
    .opaque     (opaque)
  );

  function automatic logic [5:0] rom_fn(input logic [13:0] a);
    return a[5:0] ^ 6'h15;
  endfunction

  always @(posedge clk) rom_data <= rom_zero ? 6'h00 : rom_fn(rom_addr);

  always @(posedge clk) if (rst_n && hop_done) done_cnt <= done_cnt + 1;

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    frame_tick = 1'b1;
    step_clk(1);
    frame_tick = 1'b0;
    step_clk(1);
  endtask

  task automatic do_spawn(input logic [9:0] x, input logic [9:0] y);
    spawn = 1'b1; spawn_x = x; spawn_y = y;
    step_clk(1);
    spawn = 1'b0;
  endtask

  logic [1:0] exp_frame [8];

  initial begin
    exp_frame = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    rst_n = 1'b1; frame_tick = 1'b0; spawn = 1'b0; hop_req = 1'b0;
    spawn_x = '0; spawn_y = '0; hop_dir = '0; colPos = '0; rowPos = '0;
    rom_zero = 1'b0;
    #3 rst_n = 1'b0;
    step_clk(2);
    chk("rst_frog_x", 32'(frog_x), 0);
    chk("rst_frog_y", 32'(frog_y), 0);
    chk("rst_hop_ready", 32'(hop_ready), 1);
    chk("rst_hop_done", 32'(hop_done), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_color", 32'(color), 0);
    chk("rst_opaque", 32'(opaque), 0);
    rst_n = 1'b1;
    step_clk(1);

    // Full hop right from (100,200)
    do_spawn(10'd100, 10'd200);
    chk("spawn_x", 32'(frog_x), 100);
    chk("spawn_y", 32'(frog_y), 200);
    hop_req = 1'b1; hop_dir = 2'd1;
    step_clk(1);
    hop_req = 1'b0;
    chk("hop_busy", 32'(hop_ready), 0);
    done_base = done_cnt;
    for (int k = 1; k <= 8; k++) begin
      step_clk(2);
      chk($sformatf("frame_s%0d", k - 1), 32'(rom_addr[11:10]), 32'(exp_frame[k-1]));
      frame_tick = 1'b1;
      step_clk(1);
      frame_tick = 1'b0;
      chk($sformatf("draw_x_t%0d", k), 32'(u_dut.draw_x), 32'(100 + 4 * k));
      chk($sformatf("hop_done_t%0d", k), 32'(hop_done), (k == 8) ? 32'd1 : 32'd0);
      if (k == 4) chk("frog_x_mid", 32'(frog_x), 100);
    end
    step_clk(2);
    chk("hop_done_once", 32'(done_cnt - done_base), 1);
    chk("land_x", 32'(frog_x), 132);
    chk("land_ready", 32'(hop_ready), 1);
    chk("land_frame", 32'(rom_addr[11:10]), 0);
    chk("land_facing", 32'(rom_addr[13:12]), 1);

    // Blocked hop left at x=0
    do_spawn(10'd0, 10'd64);
    done_base = done_cnt;
    hop_req = 1'b1; hop_dir = 2'd3;
    step_clk(1);
    hop_req = 1'b0;
    chk("edge_ready", 32'(hop_ready), 1);
    tick();
    step_clk(1);
    chk("edge_facing", 32'(rom_addr[13:12]), 3);
    chk("edge_frog_x", 32'(frog_x), 0);
    chk("edge_no_done", 32'(done_cnt - done_base), 0);

    // Spawn aborts a hop down after 4 ticks; simultaneous hop dropped
    do_spawn(10'd200, 10'd100);
    done_base = done_cnt;
    hop_req = 1'b1; hop_dir = 2'd2;
    step_clk(1);
    hop_req = 1'b0;
    repeat (4) tick();
    chk("abort_mid_y", 32'(frog_y), 100);
    chk("abort_draw_y", 32'(u_dut.draw_y), 116);
    spawn = 1'b1; spawn_x = 10'd300; spawn_y = 10'd50;
    hop_req = 1'b1; hop_dir = 2'd1;
    step_clk(1);
    spawn = 1'b0; hop_req = 1'b0;
    chk("abort_x", 32'(frog_x), 300);
    chk("abort_y", 32'(frog_y), 50);
    chk("abort_ready", 32'(hop_ready), 1);
    repeat (8) tick();
    step_clk(1);
    chk("abort_no_done", 32'(done_cnt - done_base), 0);
    chk("abort_drop_x", 32'(frog_x), 300);
    chk("abort_draw_x", 32'(u_dut.draw_x), 300);

    // Pixel pipeline at (64,64)
    do_spawn(10'd64, 10'd64);
    step_clk(1);
    colPos = 10'd70; rowPos = 10'd65;
    step_clk(1);
    chk("pix_addr", 32'(rom_addr), 32'h0026);
    colPos = 10'd63;
    step_clk(1);
    colPos = 10'd96;
    step_clk(1);
    chk("pix_color", 32'(color), 32'h33);
    chk("pix_opaque", 32'(opaque), 1);
    colPos = 10'd95; rowPos = 10'd95;
    step_clk(1);
    chk("left_opaque", 32'(opaque), 0);
    chk("left_color", 32'(color), 0);
    chk("corner_addr", 32'(rom_addr), 32'h03FF);
    colPos = 10'd64; rowPos = 10'd64;
    step_clk(1);
    chk("right_opaque", 32'(opaque), 0);
    chk("right_color", 32'(color), 0);
    step_clk(1);
    chk("corner_color", 32'(color), 32'h2A);
    chk("corner_opaque", 32'(opaque), 1);
    step_clk(1);
    chk("origin_color", 32'(color), 32'h15);

    // Key-coloured pixel inside the sprite
    rom_zero = 1'b1;
    colPos = 10'd70; rowPos = 10'd65;
    step_clk(3);
`ifdef TRANSPARENT_KEY_EN
    chk("key_opaque", 32'(opaque), 0);
`else
    chk("key_opaque", 32'(opaque), 1);
`endif
    chk("key_color", 32'(color), 0);
    rom_zero = 1'b0;

    // Reset in the middle of a hop
    colPos = 10'd80; rowPos = 10'd70;
    hop_req = 1'b1; hop_dir = 2'd1;
    step_clk(1);
    hop_req = 1'b0;
    repeat (2) tick();
    step_clk(2);
    chk("pre_rst_opaque", 32'(opaque), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(frog_x), 0);
    chk("mid_rst_ready", 32'(hop_ready), 1);
    chk("mid_rst_opaque", 32'(opaque), 0);
    chk("mid_rst_addr", 32'(rom_addr), 0);
    chk("mid_rst_draw_x", 32'(u_dut.draw_x), 0);
    step_clk(1);
    rst_n = 1'b1;
    step_clk(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
